// File: rtl/cache_mem_controller_if.sv
// CPU / cache / memory signal bundle for cache_mem_controller.
// The controller connects through the slave modport; the environment connects through the master modport.
interface cache_mem_controller_if #(
  parameter int WORD_W = 32,
  parameter int ADDR_W = 15,
  parameter int CNT_W  = 16
);
  logic              cpu_read;
  logic              cpu_write;
  logic [ADDR_W-1:0] cpu_addr;
  logic [WORD_W-1:0] cpu_wdata;
  logic              cpu_stall;
  logic              cpu_done;
  logic [WORD_W-1:0] cpu_rdata;
  logic [ADDR_W-1:0] cache_addr;
  logic              cache_hit;
  logic [WORD_W-1:0] cache_rdata;
  logic              cache_fill;
  logic              cache_inval;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_read;
  logic              mem_write;
  logic [WORD_W-1:0] mem_wdata;
  logic [CNT_W-1:0]  hit_count;
  logic [CNT_W-1:0]  miss_count;

  modport slave (
    input  cpu_read, cpu_write, cpu_addr, cpu_wdata, cache_hit, cache_rdata,
    output cpu_stall, cpu_done, cpu_rdata, cache_addr, cache_fill, cache_inval,
           mem_addr, mem_read, mem_write, mem_wdata, hit_count, miss_count
  );

  modport master (
    output cpu_read, cpu_write, cpu_addr, cpu_wdata, cache_hit, cache_rdata,
    input  cpu_stall, cpu_done, cpu_rdata, cache_addr, cache_fill, cache_inval,
           mem_addr, mem_read, mem_write, mem_wdata, hit_count, miss_count
  );
endinterface

// File: rtl/cache_mem_controller.sv
// Single-outstanding request sequencer for a direct-mapped cache with a write-through,
// no-allocate data memory. It also keeps saturating read hit/miss statistics.
module cache_mem_controller #(
  parameter int WORD_W      = 32,
  parameter int ADDR_W      = 15,
  parameter int MEM_LATENCY = 4,
  parameter int CNT_W       = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  cache_mem_controller_if.slave  bus
);
  localparam int LAT_W = $clog2(MEM_LATENCY + 1);

  typedef enum logic [2:0] {IDLE, LOOKUP, MEM_RD, FILL, RESP, WR} state_e;

  state_e            state_q, state_d;
  logic              op_wr_q, op_wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic              done_q, done_d;
  logic [WORD_W-1:0] rdata_q, rdata_d;
  logic [CNT_W-1:0]  hit_q, hit_d;
  logic [CNT_W-1:0]  miss_q, miss_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_wr_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      lat_q   <= '0;
      done_q  <= 1'b0;
      rdata_q <= '0;
      hit_q   <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      op_wr_q <= op_wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      lat_q   <= lat_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_wr_d = op_wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    lat_d   = lat_q;
    done_d  = 1'b0;
    rdata_d = rdata_q;
    hit_d   = hit_q;
    miss_d  = miss_q;
    case (state_q)
      IDLE: begin
        // A request still high in the done cycle belongs to the previous transaction.
        if ((bus.cpu_read || bus.cpu_write) && !done_q) begin
          op_wr_d = bus.cpu_write;
          addr_d  = bus.cpu_addr;
          wdata_d = bus.cpu_wdata;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (op_wr_q) begin
          lat_d   = LAT_W'(MEM_LATENCY);
          state_d = WR;
        end else if (bus.cache_hit) begin
          rdata_d = bus.cache_rdata;
          done_d  = 1'b1;
          if (hit_q != '1) hit_d = hit_q + CNT_W'(1);
          state_d = IDLE;
        end else begin
          if (miss_q != '1) miss_d = miss_q + CNT_W'(1);
          lat_d   = LAT_W'(MEM_LATENCY);
          state_d = MEM_RD;
        end
      end
      MEM_RD: begin
        lat_d = lat_q - LAT_W'(1);
        if (lat_q <= LAT_W'(1)) state_d = FILL;
      end
      FILL: state_d = RESP;
      RESP: begin
        rdata_d = bus.cache_rdata;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      WR: begin
        lat_d = lat_q - LAT_W'(1);
        if (lat_q <= LAT_W'(1)) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Strobes come from state alone so reset removes them immediately.
  assign bus.cpu_stall   = (state_q != IDLE);
  assign bus.cpu_done    = done_q;
  assign bus.cpu_rdata   = rdata_q;
  assign bus.cache_addr  = addr_q;
  assign bus.mem_addr    = addr_q;
  assign bus.mem_wdata   = wdata_q;
  assign bus.cache_inval = (state_q == LOOKUP) && op_wr_q;
  assign bus.mem_read    = (state_q == MEM_RD) || (state_q == FILL);
  assign bus.cache_fill  = (state_q == FILL);
  assign bus.mem_write   = (state_q == WR);
  assign bus.hit_count   = hit_q;
  assign bus.miss_count  = miss_q;
endmodule

// File: tb/tb_cache_mem_controller.sv
// Directed bench for cache_mem_controller: a vector table of whole transactions with expected
// strobe timing, plus hand sequences for held requests, reset mid-miss and counter saturation.
module tb_cache_mem_controller;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cache_mem_controller_if #(.WORD_W(32), .ADDR_W(15), .CNT_W(16)) bus ();
  cache_mem_controller_if #(.WORD_W(32), .ADDR_W(15), .CNT_W(4))  bus4 ();

  cache_mem_controller #(.WORD_W(32), .ADDR_W(15), .MEM_LATENCY(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .bus(bus));
  cache_mem_controller #(.WORD_W(32), .ADDR_W(15), .MEM_LATENCY(4), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4));

  typedef struct {
    logic        wr;
    logic        rd;
    logic [14:0] addr;
    logic [31:0] wdata;
    logic        hit;
    logic [31:0] crdata;
    logic [31:0] fill;
    int          e_done;
    int          e_rd_n;
    int          e_rd_first;
    int          e_fill;
    int          e_inval;
    int          e_wr_n;
    logic [31:0] e_rdata;
    int          e_hit;
    int          e_miss;
  } vec_t;

  vec_t vecs[7];
  int total = 0;
  int passed = 0;

  int o_done, o_rd_n, o_rd_first, o_fill, o_fill_n, o_inval, o_inval_n;
  int o_wr_n, o_wr_first, o_route_bad, o_stall_bad;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  // Runs one transaction on bus, recording when each strobe appears (cycle 0 = request sampled).
  task automatic run_txn(input vec_t v);
    int  c;
    bit  seen;
    @(negedge clk);
    bus.cache_hit = v.hit; bus.cache_rdata = v.crdata;
    bus.cpu_read = v.rd; bus.cpu_write = v.wr; bus.cpu_addr = v.addr; bus.cpu_wdata = v.wdata;
    o_done = 0; o_rd_n = 0; o_rd_first = 0; o_fill = 0; o_fill_n = 0; o_inval = 0; o_inval_n = 0;
    o_wr_n = 0; o_wr_first = 0; o_route_bad = 0; o_stall_bad = 0;
    c = 0; seen = 0;
    while (!seen && c < 40) begin
      @(posedge clk); c++; @(negedge clk);
      if (bus.mem_read) begin if (o_rd_n == 0) o_rd_first = c; o_rd_n++; end
      if (bus.cache_inval) begin o_inval = c; o_inval_n++; end
      if (bus.mem_write) begin
        if (o_wr_n == 0) o_wr_first = c;
        o_wr_n++;
        if (bus.mem_wdata !== v.wdata) o_route_bad++;
      end
      if (bus.mem_addr !== v.addr || bus.cache_addr !== v.addr) o_route_bad++;
      if (bus.cpu_done == bus.cpu_stall) o_stall_bad++;
      if (bus.cache_fill) begin
        o_fill = c; o_fill_n++;
        bus.cache_rdata = v.fill; bus.cache_hit = 1'b1;
      end
      if (bus.cpu_done) begin
        seen = 1; o_done = c;
        bus.cpu_read = 1'b0; bus.cpu_write = 1'b0;
      end else if (c == 1) begin
        bus.cpu_addr = ~v.addr; bus.cpu_wdata = ~v.wdata;
      end
    end
  endtask

  initial begin
    bus.cpu_read = 0; bus.cpu_write = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.cache_hit = 0; bus.cache_rdata = '0;
    bus4.cpu_read = 0; bus4.cpu_write = 0; bus4.cpu_addr = '0; bus4.cpu_wdata = '0;
    bus4.cache_hit = 1; bus4.cache_rdata = 32'h0000_0F0F;

    vecs[0] = '{1'b0, 1'b1, 15'h0010, 32'h0, 1'b1, 32'hDEADBEEF, 32'h0,       2, 0, 0, 0, 0, 0, 32'hDEADBEEF, 1, 0};
    vecs[1] = '{1'b0, 1'b1, 15'h0020, 32'h0, 1'b0, 32'h0BADF00D, 32'h12345678, 8, 5, 2, 6, 0, 0, 32'h12345678, 1, 1};
    vecs[2] = '{1'b1, 1'b0, 15'h0030, 32'hA5A5A5A5, 1'b1, 32'h0, 32'h0,        6, 0, 0, 0, 1, 4, 32'h12345678, 1, 1};
    vecs[3] = '{1'b1, 1'b1, 15'h0040, 32'h5A5A0001, 1'b1, 32'hFFFFFFFF, 32'h0, 6, 0, 0, 0, 1, 4, 32'h12345678, 1, 1};
    vecs[4] = '{1'b0, 1'b1, 15'h0041, 32'h0, 1'b1, 32'h00C0FFEE, 32'h0,       2, 0, 0, 0, 0, 0, 32'h00C0FFEE, 2, 1};
    vecs[5] = '{1'b1, 1'b0, 15'h7FFF, 32'hFFFFFFFF, 1'b0, 32'h0, 32'h0,        6, 0, 0, 0, 1, 4, 32'h00C0FFEE, 2, 1};
    vecs[6] = '{1'b0, 1'b1, 15'h7FFF, 32'h0, 1'b0, 32'h0, 32'hCAFEF00D,       8, 5, 2, 6, 0, 0, 32'hCAFEF00D, 2, 2};

    repeat (3) @(negedge clk);
    chk("reset_stall", bus.cpu_stall, 0);
    chk("reset_done", bus.cpu_done, 0);
    chk("reset_rdata", bus.cpu_rdata, 0);
    chk("reset_strobes", {bus.mem_read, bus.mem_write, bus.cache_fill, bus.cache_inval}, 0);
    chk("reset_counts", {bus.hit_count, bus.miss_count}, 0);
    chk("reset_addr", bus.mem_addr, 0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run_txn(vecs[i]);
      chk($sformatf("v%0d_done_cycle", i), o_done, vecs[i].e_done);
      chk($sformatf("v%0d_mem_read_n", i), o_rd_n, vecs[i].e_rd_n);
      chk($sformatf("v%0d_mem_read_first", i), o_rd_first, vecs[i].e_rd_first);
      chk($sformatf("v%0d_fill_cycle", i), o_fill, vecs[i].e_fill);
      chk($sformatf("v%0d_fill_n", i), o_fill_n, (vecs[i].e_fill != 0) ? 1 : 0);
      chk($sformatf("v%0d_inval_cycle", i), o_inval, vecs[i].e_inval);
      chk($sformatf("v%0d_inval_n", i), o_inval_n, vecs[i].e_inval);
      chk($sformatf("v%0d_mem_write_n", i), o_wr_n, vecs[i].e_wr_n);
      chk($sformatf("v%0d_mem_write_first", i), o_wr_first, (vecs[i].e_wr_n != 0) ? 2 : 0);
      chk($sformatf("v%0d_routing", i), o_route_bad, 0);
      chk($sformatf("v%0d_stall", i), o_stall_bad, 0);
      chk($sformatf("v%0d_rdata", i), bus.cpu_rdata, vecs[i].e_rdata);
      chk($sformatf("v%0d_hit_count", i), bus.hit_count, vecs[i].e_hit);
      chk($sformatf("v%0d_miss_count", i), bus.miss_count, vecs[i].e_miss);
    end

    // Request held through the done cycle: accepted at cycles 0 and 3, done at 2 and 5.
    begin
      logic [7:0] mask;
      mask = '0;
      @(negedge clk);
      bus.cpu_read = 1; bus.cpu_write = 0; bus.cpu_addr = 15'h0005;
      bus.cache_hit = 1; bus.cache_rdata = 32'h11112222;
      for (int c = 1; c <= 7; c++) begin
        @(negedge clk);
        mask[c] = bus.cpu_done;
        if (c == 5) bus.cpu_read = 0;
      end
      chk("held_done_pattern", mask, 8'b0010_0100);
      chk("held_hit_count", bus.hit_count, 4);
      chk("held_rdata", bus.cpu_rdata, 32'h11112222);
    end

    // Reset in cycle 4 of a read miss.
    begin
      int dn;
      dn = 0;
      @(negedge clk);
      bus.cpu_read = 1; bus.cpu_addr = 15'h0123; bus.cache_hit = 0; bus.cache_rdata = 32'h0;
      for (int c = 1; c <= 4; c++) begin
        @(negedge clk);
        if (bus.cpu_done) dn++;
      end
      chk("rstmid_mem_read_before", bus.mem_read, 1);
      rst = 1'b1;
      #1;
      chk("rstmid_mem_read_drop", bus.mem_read, 0);
      chk("rstmid_stall", bus.cpu_stall, 0);
      chk("rstmid_counts", {bus.hit_count, bus.miss_count}, 0);
      chk("rstmid_addr", bus.mem_addr, 0);
      bus.cpu_read = 0;
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        if (bus.cpu_done) dn++;
      end
      rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        if (bus.cpu_done) dn++;
      end
      chk("rstmid_no_done", dn, 0);
      run_txn('{1'b0, 1'b1, 15'h0011, 32'h0, 1'b1, 32'h76543210, 32'h0, 2, 0, 0, 0, 0, 0, 32'h76543210, 1, 0});
      chk("post_rst_done_cycle", o_done, 2);
      chk("post_rst_rdata", bus.cpu_rdata, 32'h76543210);
      chk("post_rst_hit_count", bus.hit_count, 1);
      chk("post_rst_miss_count", bus.miss_count, 0);
    end

    // Saturation on the 4-bit counter instance.
    for (int i = 1; i <= 17; i++) begin
      int w;
      @(negedge clk);
      bus4.cpu_read = 1;
      w = 0;
      while (!bus4.cpu_done && w < 10) begin @(negedge clk); w++; end
      bus4.cpu_read = 0;
      if (w >= 10) chk($sformatf("sat_timeout_%0d", i), 1, 0);
      if (i == 14) chk("sat_count_14", bus4.hit_count, 4'hE);
      if (i == 15) chk("sat_count_15", bus4.hit_count, 4'hF);
      if (i == 17) chk("sat_count_17", bus4.hit_count, 4'hF);
    end
    chk("sat_miss_count", bus4.miss_count, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
